bus_ram_slave: RTL and testbench

Word-addressed, byte-maskable RAM target on the `bus` fabric, directly downstream of `bus_master`. Consumes `bus::m2s_s` requests and produces `bus::s2m_s` responses (`ack`/`stall`/`err`/`data`). Response timing is chosen so the master never flags a timeout: every accepted request sees either `stall` or a response in the following cycle. It provides on-chip instruction/data memory for the core and a reference target for bus verification.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_ram_core.sv | 23 ++
 rtl/bus_ram_slave.sv | 119 +++++++++++
 tb/tb_bus_ram_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus fabric types: master-to-slave request, slave-to-master response,
// and the RAM slave's state encoding.
package bus;

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] data;
      logic [29:0] addr;
   } m2s_s;

   typedef struct packed {
      logic [31:0] data;
      logic        ack;
      logic        stall;
      logic        err;
   } s2m_s;

   typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_RESP} ramslave_state_e;

   localparam int BUS_MAX_WAIT = 15;

endpackage

// File: rtl/bus_ram_core.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables and a
// read register that only updates when en is high.
module bus_ram_core #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic [3:0]            be,
   input  logic                  en,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (en) rdata <= mem[addr];
   end

endmodule

// File: rtl/bus_ram_slave.sv
// Byte-maskable RAM target on the bus fabric with configurable wait states.
// Optional out-of-range error responses: define BUS_RAM_SLAVE_RANGE_ERR_EN.
module bus_ram_slave import bus::*; #(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_STATES = 0,
   parameter logic [29:0] BASE_ADDR   = 30'h0
) (
   input  logic clk,
   input  logic rst,
   input  m2s_s bus_i,
   output s2m_s bus_o
);

   localparam int                CNT_W    = $clog2(BUS_MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   ramslave_state_e       state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic                  stall_p1;
   logic                  we_p1, inr_p1;
   logic [31:0]           rdata_p1;
   logic                  accept, in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic [3:0]            be;

   // Request decode (cycle of acceptance)
   assign accept = bus_i.cyc & bus_i.stb & ~stall_p1;
   assign idx    = DEPTH_LOG2'(bus_i.addr - BASE_ADDR);

`ifdef BUS_RAM_SLAVE_RANGE_ERR_EN
   localparam logic [30:0] DEPTH = 31'(1) << DEPTH_LOG2;
   logic [29:0] offset;
   assign offset   = bus_i.addr - BASE_ADDR;
   assign in_range = {1'b0, offset} < DEPTH;
`else
   assign in_range = 1'b1;
`endif

   assign be = (accept & bus_i.we & in_range) ? bus_i.sel : 4'b0000;

   bus_ram_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_core (
      .clk   (clk),
      .be    (be),
      .en    (accept & ~bus_i.we),
      .addr  (idx),
      .wdata (bus_i.data),
      .rdata (rdata_p1)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         RS_IDLE, RS_RESP: begin
            state_nx = RS_IDLE;
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_nx = RS_RESP;
               end else begin
                  state_nx = RS_WAIT;
                  cnt_nx   = CNT_LOAD;
               end
            end
         end
         RS_WAIT: begin
            // A dropped cyc abandons the transfer; a write has already landed.
            if (!bus_i.cyc) begin
               state_nx = RS_IDLE;
               cnt_nx   = '0;
            end else if (cnt == '0) begin
               state_nx = RS_RESP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = RS_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Control registers (stage 1)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= RS_IDLE;
         cnt      <= '0;
         stall_p1 <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         stall_p1 <= (state_nx == RS_WAIT);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_p1  <= bus_i.we;
         inr_p1 <= in_range;
      end
   end

   // Response muxing (stage 1 outputs)
   always_comb begin
      bus_o       = '0;
      bus_o.stall = stall_p1;
      if (state == RS_RESP) begin
`ifdef BUS_RAM_SLAVE_RANGE_ERR_EN
         bus_o.ack = inr_p1;
         bus_o.err = ~inr_p1;
`else
         bus_o.ack = 1'b1;
         bus_o.err = 1'b0;
`endif
         if (!we_p1 && inr_p1) bus_o.data = rdata_p1;
      end
   end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: three instances (0, 3 and 2 wait states, one with a
// wrapping base address) checked every cycle against a transaction-level model.
module tb_bus_ram_slave;
   import bus::*;

   logic clk = 1'b0;
   logic rst;
   m2s_s req [3];
   s2m_s rsp [3];

   always #5 clk = ~clk;

   bus_ram_slave #(.DEPTH_LOG2(4), .WAIT_STATES(0), .BASE_ADDR(30'h100)) dut0 (
      .clk(clk), .rst(rst), .bus_i(req[0]), .bus_o(rsp[0]));
   bus_ram_slave #(.DEPTH_LOG2(4), .WAIT_STATES(3), .BASE_ADDR(30'h0)) dut1 (
      .clk(clk), .rst(rst), .bus_i(req[1]), .bus_o(rsp[1]));
   bus_ram_slave #(.DEPTH_LOG2(4), .WAIT_STATES(2), .BASE_ADDR(30'h3FFF_FFF8)) dut2 (
      .clk(clk), .rst(rst), .bus_i(req[2]), .bus_o(rsp[2]));

   int          ws   [3] = '{0, 3, 2};
   logic [29:0] base [3] = '{30'h100, 30'h0, 30'h3FFF_FFF8};

   // Reference model: memory image plus the one outstanding transfer per target
   logic [31:0] mem  [3][16];
   bit          pend [3];
   int          due  [3];
   bit          p_we [3];
   bit          p_inr[3];
   logic [31:0] p_rd [3];
   bit          acc  [3];
   int          cyc_n;
   int          nvec;
   int          nerr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Applies the spec rules to the inputs being driven in cycle cyc_n.
   task automatic model_cycle();
      for (int d = 0; d < 3; d++) begin
         logic [29:0] off;
         bit          stalled;
         bit          inr;
         int          idx;
         acc[d] = 1'b0;
         if (!rst) begin
            pend[d] = 1'b0;
            continue;
         end
         stalled = pend[d] && (cyc_n < due[d]);
         if (stalled && !req[d].cyc) pend[d] = 1'b0;
         if (pend[d] && cyc_n >= due[d]) pend[d] = 1'b0;
         if (req[d].cyc && req[d].stb && !stalled) begin
            off = req[d].addr - base[d];
            idx = int'(off[3:0]);
`ifdef BUS_RAM_SLAVE_RANGE_ERR_EN
            inr = (off < 30'd16);
`else
            inr = 1'b1;
`endif
            acc[d]   = 1'b1;
            pend[d]  = 1'b1;
            due[d]   = cyc_n + 1 + ws[d];
            p_we[d]  = req[d].we;
            p_inr[d] = inr;
            p_rd[d]  = mem[d][idx];
            if (req[d].we && inr) begin
               for (int b = 0; b < 4; b++) begin
                  if (req[d].sel[b]) mem[d][idx][8*b +: 8] = req[d].data[8*b +: 8];
               end
            end
         end
      end
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      #1;
      cyc_n++;
      for (int d = 0; d < 3; d++) begin
         bit resp;
         resp = pend[d] && (cyc_n == due[d]);
         chk($sformatf("d%0d_stall@%0d", d, cyc_n), rsp[d].stall, pend[d] && (cyc_n < due[d]));
         chk($sformatf("d%0d_ack@%0d", d, cyc_n), rsp[d].ack, resp && p_inr[d]);
         chk($sformatf("d%0d_err@%0d", d, cyc_n), rsp[d].err, resp && !p_inr[d]);
         chk($sformatf("d%0d_data@%0d", d, cyc_n), rsp[d].data,
             (resp && !p_we[d] && p_inr[d]) ? p_rd[d] : 32'h0);
      end
   endtask

   task automatic idle(input int d);
      req[d] = '0;
   endtask

   // Holds a request until the target accepts it; leaves cyc asserted.
   task automatic put(input int d, input bit we, input logic [3:0] sel,
                      input logic [31:0] data, input logic [29:0] addr, output int n);
      req[d].cyc  = 1'b1;
      req[d].stb  = 1'b1;
      req[d].we   = we;
      req[d].sel  = sel;
      req[d].data = data;
      req[d].addr = addr;
      n = 0;
      do begin
         step();
         n++;
      end while (!acc[d] && n < 20);
      chk($sformatf("d%0d_accept", d), acc[d], 1'b1);
      req[d].stb = 1'b0;
   endtask

   initial begin
      int n;
      nvec  = 0;
      nerr  = 0;
      cyc_n = 0;
      rst   = 1'b0;
      for (int d = 0; d < 3; d++) begin
         idle(d);
         pend[d] = 1'b0;
         acc[d]  = 1'b0;
      end

      repeat (3) step();
      chk("reset_state", dut1.state, RS_IDLE);
      rst = 1'b1;
      step();

      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 16; i++) put(d, 1'b1, 4'hF, $urandom, base[d] + 30'(i), n);
         repeat (4) step();
         idle(d);
      end
      step();

      // Zero-wait back-to-back write then read
      put(0, 1'b1, 4'hF, 32'hDEAD_BEEF, base[0] + 30'd5, n);
      put(0, 1'b0, 4'hF, 32'h0, base[0] + 30'd5, n);
      chk("zw_b2b_latency", n, 1);
      chk("zw_rd_data", rsp[0].data, 32'hDEAD_BEEF);
      idle(0);
      step();

      // Byte mask
      put(0, 1'b1, 4'hF, 32'hFFFF_FFFF, base[0] + 30'd7, n);
      put(0, 1'b1, 4'b0101, 32'h1122_3344, base[0] + 30'd7, n);
      put(0, 1'b0, 4'hF, 32'h0, base[0] + 30'd7, n);
      chk("mask_data", rsp[0].data, 32'hFF22_FF44);
      idle(0);
      step();

      // Out-of-range write, then sweep the whole window
      put(0, 1'b1, 4'hF, 32'hA5A5_5A5A, 30'h110, n);
`ifdef BUS_RAM_SLAVE_RANGE_ERR_EN
      chk("rng_err", rsp[0].err, 1'b1);
      chk("rng_ack", rsp[0].ack, 1'b0);
`else
      chk("rng_err", rsp[0].err, 1'b0);
      chk("rng_ack", rsp[0].ack, 1'b1);
`endif
      for (int i = 0; i < 16; i++) put(0, 1'b0, 4'hF, 32'h0, base[0] + 30'(i), n);
      put(0, 1'b0, 4'hF, 32'h0, 30'h100, n);
`ifndef BUS_RAM_SLAVE_RANGE_ERR_EN
      chk("rng_alias_idx0", rsp[0].data, 32'hA5A5_5A5A);
`endif
      idle(0);
      step();

      // Wait states: a held strobe is taken only in the response cycle
      put(1, 1'b0, 4'hF, 32'h0, 30'd3, n);
      chk("ws_first_latency", n, 1);
      put(1, 1'b0, 4'hF, 32'h0, 30'd4, n);
      chk("ws_held_cycles", n, 4);
      repeat (4) step();
      idle(1);
      step();

      // Abort during wait
      put(2, 1'b0, 4'hF, 32'h0, base[2] + 30'd1, n);
      req[2].cyc = 1'b0;
      step();
      chk("abort_state", dut2.state, RS_IDLE);
      repeat (3) step();
      put(2, 1'b0, 4'hF, 32'h0, base[2] + 30'd1, n);
      chk("abort_next_latency", n, 1);
      repeat (3) step();
      idle(2);
      step();

      // Reset while waiting; the committed write must survive
      put(1, 1'b1, 4'hF, 32'hC0FF_EE11, 30'd9, n);
      rst = 1'b0;
      idle(1);
      step();
      chk("rst_state", dut1.state, RS_IDLE);
      chk("rst_stall", rsp[1].stall, 1'b0);
      rst = 1'b1;
      put(1, 1'b0, 4'hF, 32'h0, 30'd9, n);
      repeat (3) step();
      chk("rst_persist", rsp[1].data, 32'hC0FF_EE11);
      idle(1);
      step();

      // Randomized traffic on all three targets
      for (int k = 0; k < 600; k++) begin
         for (int d = 0; d < 3; d++) begin
            req[d].cyc  = ($urandom_range(0, 15) != 0);
            req[d].stb  = ($urandom_range(0, 2) != 0);
            req[d].we   = 1'($urandom_range(0, 1));
            req[d].sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            req[d].data = $urandom;
            req[d].addr = ($urandom_range(0, 7) == 0) ? 30'($urandom)
                                                      : base[d] + 30'($urandom_range(0, 17));
         end
         step();
      end
      for (int d = 0; d < 3; d++) idle(d);
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
